// File: rtl/in_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : in_debounce
//  Description : Input conditioning for a raw asynchronous pin. The pin is
//                brought into the CLK domain through a plain flop chain and
//                then debounced by a four-state qualifier. A new level is
//                accepted only after the synchronised input has disagreed
//                with the current level for DB_CYCLES consecutive enabled
//                cycles. Single-cycle RISE/FALL pulses accompany each level
//                change, and GLITCH pulses when a qualification is aborted
//                because the input went back.
//
//  Ports       :
//    CLK     in   1  clock, all flops on the rising edge
//    RST     in   1  asynchronous active-low reset
//    IN      in   1  raw asynchronous pin
//    EN      in   1  debounce enable (synchronous)
//    LEVEL   out  1  debounced level
//    RISE    out  1  one-cycle pulse in the cycle LEVEL goes 0->1
//    FALL    out  1  one-cycle pulse in the cycle LEVEL goes 1->0
//    BUSY    out  1  high while a transition is being qualified
//    GLITCH  out  1  one-cycle pulse when a qualification aborts
//
//  Parameters  :
//    SYNC_STAGES  synchroniser depth, 2..4
//    DB_CYCLES    qualification length in cycles, 1..2^CNT_W
//    CNT_W        qualification counter width
//
//  Revision    : 1.0  initial release
// ============================================================================
module in_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int CNT_W       = 5
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  input  logic EN,
  output logic LEVEL,
  output logic RISE,
  output logic FALL,
  output logic BUSY,
  output logic GLITCH
);

  // --------------------------------------------------------------------------
  // State encoding and constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_LOW      = 2'd0;
  localparam logic [1:0] S_RISE_CHK = 2'd1;
  localparam logic [1:0] S_HIGH     = 2'd2;
  localparam logic [1:0] S_FALL_CHK = 2'd3;

  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  // Last counter value of a qualification; the counter never goes past it.
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);
  // With a one-cycle qualification the first disagreeing sample is already
  // sufficient, so the stable states switch directly to each other.
  localparam bit               c_SINGLE   = (DB_CYCLES == 1);

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   glitch_q;
  logic                   glitch_d;

  // --------------------------------------------------------------------------
  // Synchroniser: bare shift chain, nothing between stages
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], IN};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // FSM state register, qualification counter and registered pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_LOW;
      cnt_q    <= c_CNT_ZERO;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  //
  // In a check state EN is examined first: dropping the enable abandons the
  // check silently, even in the cycle that would otherwise qualify.
  // A single sample that agrees with the current level aborts the check and
  // clears the counter, so counting never carries across an abort.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;

    case (state_q)
      S_LOW: begin
        if (sync && EN) begin
          if (c_SINGLE) begin
            state_d = S_HIGH;
            cnt_d   = c_CNT_ZERO;
            rise_d  = 1'b1;
          end else begin
            state_d = S_RISE_CHK;
            cnt_d   = c_CNT_ONE;
          end
        end
      end

      S_RISE_CHK: begin
        if (!EN) begin
          state_d = S_LOW;
          cnt_d   = c_CNT_ZERO;
        end else if (!sync) begin
          state_d  = S_LOW;
          cnt_d    = c_CNT_ZERO;
          glitch_d = 1'b1;
        end else if (cnt_q == c_CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = c_CNT_ZERO;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end

      S_HIGH: begin
        if (!sync && EN) begin
          if (c_SINGLE) begin
            state_d = S_LOW;
            cnt_d   = c_CNT_ZERO;
            fall_d  = 1'b1;
          end else begin
            state_d = S_FALL_CHK;
            cnt_d   = c_CNT_ONE;
          end
        end
      end

      S_FALL_CHK: begin
        if (!EN) begin
          state_d = S_HIGH;
          cnt_d   = c_CNT_ZERO;
        end else if (sync) begin
          state_d  = S_HIGH;
          cnt_d    = c_CNT_ZERO;
          glitch_d = 1'b1;
        end else if (cnt_q == c_CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = c_CNT_ZERO;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = c_CNT_ZERO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM outputs: decoded from the state register or taken straight from the
  // pulse flops, so nothing reaches an output combinationally from IN or EN.
  // --------------------------------------------------------------------------
  always_comb begin
    LEVEL  = (state_q == S_HIGH) || (state_q == S_FALL_CHK);
    BUSY   = (state_q == S_RISE_CHK) || (state_q == S_FALL_CHK);
    RISE   = rise_q;
    FALL   = fall_q;
    GLITCH = glitch_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_in_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_in_debounce
//  Description : Self-checking bench for in_debounce. Two instances run side
//                by side: A with default parameters (2 sync stages, 16-cycle
//                qualification) and B with 3 sync stages and a one-cycle
//                qualification. Each clock, both are compared against a
//                behavioural model that works from the delayed pin value and
//                a run length of consecutive enabled disagreeing samples.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_in_debounce;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic in_a = 1'b0, en_a = 1'b0, in_b = 1'b0, en_b = 1'b0;
  logic lvl_a, rise_a, fall_a, busy_a, glitch_a;
  logic lvl_b, rise_b, fall_b, busy_b, glitch_b;

  always #5 CLK = ~CLK;

  in_debounce #(.SYNC_STAGES(2), .DB_CYCLES(16), .CNT_W(5)) u_dut_a (
    .CLK(CLK), .RST(RST), .IN(in_a), .EN(en_a),
    .LEVEL(lvl_a), .RISE(rise_a), .FALL(fall_a), .BUSY(busy_a), .GLITCH(glitch_a)
  );

  in_debounce #(.SYNC_STAGES(3), .DB_CYCLES(1), .CNT_W(2)) u_dut_b (
    .CLK(CLK), .RST(RST), .IN(in_b), .EN(en_b),
    .LEVEL(lvl_b), .RISE(rise_b), .FALL(fall_b), .BUSY(busy_b), .GLITCH(glitch_b)
  );

  // Model state: pipe holds the last pin samples (pipe[0] newest), run counts
  // consecutive enabled edges on which the delayed pin disagreed with level.
  typedef struct packed {
    logic       level;
    logic       rise;
    logic       fall;
    logic       glitch;
    logic       busy;
    logic [3:0] pipe;
    logic [7:0] run;
  } mdl_t;

  mdl_t ma, mb;
  int   checks   = 0;
  int   errors   = 0;
  int   tcount   = 0;
  int   b_change = -100;
  logic b_val    = 1'b0;
  bit   b_rand   = 1'b0;

  function automatic mdl_t mdl_step(input mdl_t m, input logic pin, input logic en,
                                    input int ns, input int db);
    logic s;
    s        = m.pipe[ns-1];
    m.pipe   = {m.pipe[2:0], pin};
    m.rise   = 1'b0;
    m.fall   = 1'b0;
    m.glitch = 1'b0;
    if (en && (s != m.level)) begin
      m.run = m.run + 8'd1;
      if (int'(m.run) == db) begin
        m.level = ~m.level;
        m.rise  = m.level;
        m.fall  = ~m.level;
        m.run   = 8'd0;
      end
    end else begin
      m.glitch = en && (m.run != 8'd0);
      m.run    = 8'd0;
    end
    m.busy = (m.run != 8'd0);
    return m;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("A_LEVEL",  lvl_a,    ma.level);
    chk("A_RISE",   rise_a,   ma.rise);
    chk("A_FALL",   fall_a,   ma.fall);
    chk("A_BUSY",   busy_a,   ma.busy);
    chk("A_GLITCH", glitch_a, ma.glitch);
    chk("B_LEVEL",  lvl_b,    mb.level);
    chk("B_RISE",   rise_b,   mb.rise);
    chk("B_FALL",   fall_b,   mb.fall);
    chk("B_BUSY",   busy_b,   mb.busy);
    chk("B_GLITCH", glitch_b, mb.glitch);
  endtask

  // One clock: drive inputs (caller is always just after an edge), advance
  // the models on the edge, compare 1 time unit later.
  task automatic tick(input logic ia, input logic ea);
    logic ib, eb;
    if (b_rand) begin
      ib = ($urandom_range(0, 3) == 0) ? ~b_val : b_val;
      eb = ($urandom_range(0, 9) != 0);
      b_change = -100;
    end else begin
      ib = (((tcount / 7) % 2) == 1);
      eb = 1'b1;
      if (ib != b_val) b_change = tcount;
    end
    b_val = ib;
    in_a = ia; en_a = ea; in_b = ib; en_b = eb;
    @(posedge CLK);
    ma = mdl_step(ma, ia, ea, 2, 16);
    mb = mdl_step(mb, ib, eb, 3, 1);
    #1;
    cmp_all();
    // B: a steady pin change must show on LEVEL at the 4th edge
    if (!b_rand && (b_change >= 0) && (tcount == b_change + 3))
      chk("B_FOLLOW_EDGE4", lvl_b, b_val);
    tcount++;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   n_gl, n_fall, n_rise, at;
    logic ra, ia;
    n_gl = 0; n_fall = 0; n_rise = 0; at = -1; ra = 1'b0; ia = 1'b0;
    ma = '0;
    mb = '0;

    // ---- reset state ----
    RST = 1'b0; in_a = 1'b0; en_a = 1'b1; in_b = 1'b0; en_b = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("RST_A_LEVEL",  lvl_a,    1'b0);
    chk("RST_A_RISE",   rise_a,   1'b0);
    chk("RST_A_FALL",   fall_a,   1'b0);
    chk("RST_A_BUSY",   busy_a,   1'b0);
    chk("RST_A_GLITCH", glitch_a, 1'b0);
    chk("RST_B_LEVEL",  lvl_b,    1'b0);
    chk("RST_B_BUSY",   busy_b,   1'b0);
    @(negedge CLK);
    RST = 1'b1;

    // ---- pin held low ----
    for (int k = 0; k < 50; k++) begin
      tick(1'b0, 1'b1);
      if (rise_a || fall_a || glitch_a || busy_a) n_gl++;
    end
    chk_int("LOW_HOLD_ACTIVITY", n_gl, 0);

    // ---- rising qualification latency ----
    for (int k = 1; k <= 19; k++) begin
      tick(1'b1, 1'b1);
      if (k == 2)  chk("RISE_BUSY_E2", busy_a, 1'b0);
      if (k == 3)  chk("RISE_BUSY_E3", busy_a, 1'b1);
      if (k == 17) chk("RISE_LEVEL_E17", lvl_a, 1'b0);
      if (k == 18) begin
        chk("RISE_LEVEL_E18", lvl_a, 1'b1);
        chk("RISE_PULSE_E18", rise_a, 1'b1);
      end
      if (k == 19) chk("RISE_PULSE_E19", rise_a, 1'b0);
    end

    // ---- 5-cycle dropout from high ----
    n_gl = 0; n_fall = 0;
    for (int k = 0; k < 30; k++) begin
      tick((k < 5) ? 1'b0 : 1'b1, 1'b1);
      if (glitch_a) n_gl++;
      if (fall_a) n_fall++;
    end
    chk_int("DROP_GLITCH_COUNT", n_gl, 1);
    chk_int("DROP_FALL_COUNT", n_fall, 0);
    chk("DROP_LEVEL", lvl_a, 1'b1);
    chk("DROP_BUSY", busy_a, 1'b0);

    // ---- bounce train then steady low ----
    n_fall = 0; at = -1;
    for (int i = 0; i < 40; i++) begin
      tick(((i % 6) < 3) ? 1'b0 : 1'b1, 1'b1);
      if (fall_a) n_fall++;
    end
    for (int k = 1; k <= 25; k++) begin
      tick(1'b0, 1'b1);
      if (fall_a) begin n_fall++; at = k; end
    end
    chk_int("BOUNCE_FALL_COUNT", n_fall, 1);
    chk_int("BOUNCE_FALL_EDGE", at, 18);
    chk("BOUNCE_LEVEL", lvl_a, 1'b0);

    // ---- EN dropped during a rising check ----
    n_rise = 0; n_gl = 0; at = -1;
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b1);
      if (rise_a) n_rise++;
      if (glitch_a) n_gl++;
    end
    tick(1'b1, 1'b0);
    chk("EN_OFF_BUSY", busy_a, 1'b0);
    if (glitch_a) n_gl++;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0);
      if (rise_a) n_rise++;
      if (glitch_a) n_gl++;
    end
    chk_int("EN_OFF_RISE_COUNT", n_rise, 0);
    chk_int("EN_OFF_GLITCH_COUNT", n_gl, 0);
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1, 1'b1);
      if (rise_a && at < 0) at = k;
    end
    chk_int("EN_ON_RISE_EDGE", at, 16);

    // ---- qualify and EN drop on the same edge ----
    for (int k = 1; k <= 17; k++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("SIM_NO_FALL", fall_a, 1'b0);
    chk("SIM_LEVEL_HELD", lvl_a, 1'b1);
    chk("SIM_BUSY", busy_a, 1'b0);
    at = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b1);
      if (fall_a && at < 0) at = k;
    end
    chk_int("SIM_REEN_FALL_EDGE", at, 16);

    // ---- randomized traffic on both instances ----
    b_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) ra = ~ra;
      ia = ($urandom_range(0, 19) == 0) ? ~ra : ra;
      tick(ia, ($urandom_range(0, 29) != 0));
    end
    b_rand = 1'b0;

    // ---- asynchronous reset while LEVEL is high ----
    repeat (25) tick(1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b1);
    for (int k = 0; k < 12 && lvl_b !== 1'b1; k++) tick(1'b0, 1'b1);
    chk("PRE_RST_A_LEVEL", lvl_a, 1'b1);
    chk("PRE_RST_A_BUSY", busy_a, 1'b1);
    chk("PRE_RST_B_LEVEL", lvl_b, 1'b1);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("ARST_A_LEVEL", lvl_a, 1'b0);
    chk("ARST_A_FALL", fall_a, 1'b0);
    chk("ARST_A_BUSY", busy_a, 1'b0);
    chk("ARST_B_LEVEL", lvl_b, 1'b0);
    chk("ARST_B_FALL", fall_b, 1'b0);
    @(posedge CLK);
    #1;
    chk("ARST_HOLD_A_FALL", fall_a, 1'b0);
    chk("ARST_HOLD_B_FALL", fall_b, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    ma = '0;
    mb = '0;
    b_change = -100;
    repeat (30) tick(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
